// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared types and defaults for the stopwatch controller.
//   state_e      - controller FSM state, fixed encodings
//   DefPrescale  - default clock cycles per count tick
package stopwatch_pkg;

    typedef enum logic [1:0] {
        StClear = 2'b00,
        StIdle  = 2'b01,
        StRun   = 2'b10,
        StPause = 2'b11
    } state_e;

    localparam int unsigned DefPrescale = 4;

endpackage

// File: rtl/tick_gen.sv
// tick_gen: prescaler that divides the clock into count ticks.
// Ports:
//   clk     - clock, rising edge
//   i_sclr  - synchronous active-high reset, clears the prescaler
//   i_en    - advance the prescaler this cycle
//   i_hold  - keep the current value when not advancing; with neither
//             i_en nor i_hold the prescaler returns to 0
//   o_tick  - high in the cycle the prescaler is at its last value and enabled
module tick_gen
    import stopwatch_pkg::*;
#(
    parameter int unsigned PRESCALE = DefPrescale
) (
    input  logic clk,
    input  logic i_sclr,
    input  logic i_en,
    input  logic i_hold,
    output logic o_tick
);

    localparam int unsigned PreW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PreW-1:0] PreLast = PreW'(PRESCALE - 1);

    logic [PreW-1:0] pre_q, pre_d;

    always_comb begin
        pre_d = '0;
        if (i_en) begin
            pre_d = (pre_q == PreLast) ? '0 : pre_q + PreW'(1);
        end else if (i_hold) begin
            pre_d = pre_q;
        end
    end

    always_ff @(posedge clk) begin
        if (i_sclr) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    assign o_tick = i_en && (pre_q == PreLast);

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/clear controller for a two-digit counter cascade.
// Optional feature macro: STOPWATCH_LAP_EN (adds i_lap / o_lap_hold).
// Ports:
//   clk        - clock, rising edge
//   i_sclr     - synchronous active-high reset
//   i_start    - one-cycle pulse, toggles run/pause (starts from idle)
//   i_clr      - one-cycle pulse, clears both counters; beats i_start
//   i_cnt_lo   - current value of the low counter
//   o_en_lo    - registered enable pulse to the low counter
//   o_en_hi    - registered enable pulse to the high counter (carry)
//   o_sclr_lo  - registered synchronous clear to the low counter
//   o_sclr_hi  - registered synchronous clear to the high counter
//   o_running  - registered, high while running
//   i_lap      - (STOPWATCH_LAP_EN) toggle the lap hold while running/paused
//   o_lap_hold - (STOPWATCH_LAP_EN) registered lap hold flag
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned      WIDTH    = 3,
    parameter logic [WIDTH-1:0] ULIMIT   = 3'b110,
    parameter int unsigned      PRESCALE = DefPrescale
) (
    input  logic             clk,
    input  logic             i_sclr,
    input  logic             i_start,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_cnt_lo,
    output logic             o_en_lo,
    output logic             o_en_hi,
    output logic             o_sclr_lo,
    output logic             o_sclr_hi,
    output logic             o_running
`ifdef STOPWATCH_LAP_EN
    ,
    input  logic             i_lap,
    output logic             o_lap_hold
`endif
);

    state_e st_q, st_d;
    logic   tick, carry;
    logic   en_lo_q, en_lo_d, en_hi_q, en_hi_d;
    logic   sclr_lo_q, sclr_lo_d, sclr_hi_q, sclr_hi_d;
    logic   running_q, running_d;

    always_comb begin
        st_d = st_q;
        unique case (st_q)
            StClear: st_d = StIdle;
            StIdle: begin
                if (i_clr) st_d = StClear;
                else if (i_start) st_d = StRun;
            end
            StRun: begin
                if (i_clr) st_d = StClear;
                else if (i_start) st_d = StPause;
            end
            StPause: begin
                if (i_clr) st_d = StClear;
                else if (i_start) st_d = StRun;
            end
            default: st_d = StClear;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_sclr) begin
            st_q <= StClear;
        end else begin
            st_q <= st_d;
        end
    end

    // The prescaler freezes (rather than wraps) in a cycle carrying a button
    // pulse, so a suppressed tick is not lost; it keeps its partial period
    // while paused and returns to 0 in CLEAR/IDLE.
    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk    (clk),
        .i_sclr (i_sclr),
        .i_en   ((st_q == StRun) && !i_start && !i_clr),
        .i_hold ((st_q == StRun) || (st_q == StPause)),
        .o_tick (tick)
    );

    // Carry clears the low digit instead of enabling it, so it wraps at ULIMIT.
    assign carry = tick && (i_cnt_lo == ULIMIT);

    always_comb begin
        en_lo_d   = tick && !carry;
        en_hi_d   = carry;
        sclr_lo_d = (st_q == StClear) || carry;
        sclr_hi_d = (st_q == StClear);
        running_d = (st_q == StRun);
    end

    always_ff @(posedge clk) begin
        if (i_sclr) begin
            en_lo_q   <= 1'b0;
            en_hi_q   <= 1'b0;
            sclr_lo_q <= 1'b0;
            sclr_hi_q <= 1'b0;
            running_q <= 1'b0;
        end else begin
            en_lo_q   <= en_lo_d;
            en_hi_q   <= en_hi_d;
            sclr_lo_q <= sclr_lo_d;
            sclr_hi_q <= sclr_hi_d;
            running_q <= running_d;
        end
    end

    assign o_en_lo   = en_lo_q;
    assign o_en_hi   = en_hi_q;
    assign o_sclr_lo = sclr_lo_q;
    assign o_sclr_hi = sclr_hi_q;
    assign o_running = running_q;

`ifdef STOPWATCH_LAP_EN
    logic lap_q, lap_d;

    always_comb begin
        lap_d = lap_q;
        if ((st_q == StClear) || (st_q == StIdle)) begin
            lap_d = 1'b0;
        end else if (i_lap) begin
            lap_d = !lap_q;
        end
    end

    always_ff @(posedge clk) begin
        if (i_sclr) begin
            lap_q <= 1'b0;
        end else begin
            lap_q <= lap_d;
        end
    end

    assign o_lap_hold = lap_q;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed self-checking bench for stopwatch_ctrl with
// PRESCALE=4, ULIMIT=6. Behavioural low/high counters close the loop.
// Lap scenario is built only with STOPWATCH_LAP_EN.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       i_sclr = 1'b1;
    logic       i_start = 1'b0;
    logic       i_clr = 1'b0;
    logic [2:0] cnt_lo = 3'd0;
    logic [3:0] cnt_hi = 4'd0;
    logic       o_en_lo, o_en_hi, o_sclr_lo, o_sclr_hi, o_running;
`ifdef STOPWATCH_LAP_EN
    logic       i_lap = 1'b0;
    logic       o_lap_hold;
`endif

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    stopwatch_ctrl #(
        .WIDTH    (3),
        .ULIMIT   (3'b110),
        .PRESCALE (4)
    ) dut (
        .clk       (clk),
        .i_sclr    (i_sclr),
        .i_start   (i_start),
        .i_clr     (i_clr),
        .i_cnt_lo  (cnt_lo),
        .o_en_lo   (o_en_lo),
        .o_en_hi   (o_en_hi),
        .o_sclr_lo (o_sclr_lo),
        .o_sclr_hi (o_sclr_hi),
        .o_running (o_running)
`ifdef STOPWATCH_LAP_EN
        ,
        .i_lap      (i_lap),
        .o_lap_hold (o_lap_hold)
`endif
    );

    // Stand-ins for the two counter_en instances: sclr has priority over en.
    always @(posedge clk) begin
        if (i_sclr) begin
            cnt_lo <= 3'd0;
            cnt_hi <= 4'd0;
        end else begin
            if (o_sclr_lo) cnt_lo <= 3'd0;
            else if (o_en_lo) cnt_lo <= cnt_lo + 3'd1;
            if (o_sclr_hi) cnt_hi <= 4'd0;
            else if (o_en_hi) cnt_hi <= cnt_hi + 4'd1;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        i_sclr = 1'b1;
        cyc(1);
        i_sclr = 1'b0;
        checks++;
        if (o_sclr_lo !== 1'b0 || o_en_lo !== 1'b0 || o_running !== 1'b0)
            $display("FAIL reset_vals: sclr_lo=%b en_lo=%b running=%b want 0 0 0",
                     o_sclr_lo, o_en_lo, o_running);
        else passes++;
        cyc(1);
        checks++;
        if (o_sclr_lo !== 1'b1 || o_sclr_hi !== 1'b1)
            $display("FAIL reset_sclr_pulse: lo=%b hi=%b want 1 1", o_sclr_lo, o_sclr_hi);
        else passes++;
        cyc(1);
        checks++;
        if (o_sclr_lo !== 1'b0 || o_sclr_hi !== 1'b0)
            $display("FAIL reset_sclr_end: lo=%b hi=%b want 0 0", o_sclr_lo, o_sclr_hi);
        else passes++;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            checks++;
            if (o_en_lo !== 1'b0 || cnt_lo !== 3'd0)
                $display("FAIL reset_idle_quiet: cycle %0d en_lo=%b cnt_lo=%0d want 0 0",
                         i, o_en_lo, cnt_lo);
            else passes++;
        end
    endtask

    task automatic test_count();
        i_start = 1'b1;
        cyc(1);
        i_start = 1'b0;
        checks++;
        if (o_running !== 1'b0)
            $display("FAIL count_running_lag: got %b want 0", o_running);
        else passes++;
        cyc(1);
        checks++;
        if (o_running !== 1'b1)
            $display("FAIL count_running: got %b want 1", o_running);
        else passes++;
        cyc(3);
        checks++;
        if (o_en_lo !== 1'b1 || cnt_lo !== 3'd0)
            $display("FAIL count_first_en: en_lo=%b cnt_lo=%0d want 1 0", o_en_lo, cnt_lo);
        else passes++;
        cyc(1);
        checks++;
        if (cnt_lo !== 3'd1 || o_en_lo !== 1'b0)
            $display("FAIL count_one: cnt_lo=%0d en_lo=%b want 1 0", cnt_lo, o_en_lo);
        else passes++;
        cyc(4);
        checks++;
        if (cnt_lo !== 3'd2)
            $display("FAIL count_two: cnt_lo=%0d want 2", cnt_lo);
        else passes++;
        cyc(3);
        checks++;
        if (cnt_lo !== 3'd2)
            $display("FAIL count_two_hold: cnt_lo=%0d want 2", cnt_lo);
        else passes++;
        cyc(1);
        checks++;
        if (cnt_lo !== 3'd3)
            $display("FAIL count_three: cnt_lo=%0d want 3", cnt_lo);
        else passes++;
    endtask

    task automatic test_carry();
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            checks++;
            if (cnt_lo === 3'd7 || (o_en_lo === 1'b1 && o_sclr_lo === 1'b1))
                $display("FAIL carry_guard: cycle %0d cnt_lo=%0d en_lo=%b sclr_lo=%b",
                         i, cnt_lo, o_en_lo, o_sclr_lo);
            else passes++;
        end
        checks++;
        if (cnt_lo !== 3'd6 || cnt_hi !== 4'd0)
            $display("FAIL carry_at_limit: lo=%0d hi=%0d want 6 0", cnt_lo, cnt_hi);
        else passes++;
        cyc(3);
        checks++;
        if (o_sclr_lo !== 1'b1 || o_en_hi !== 1'b1 || o_en_lo !== 1'b0 || o_sclr_hi !== 1'b0)
            $display("FAIL carry_pulses: sclr_lo=%b en_hi=%b en_lo=%b sclr_hi=%b want 1 1 0 0",
                     o_sclr_lo, o_en_hi, o_en_lo, o_sclr_hi);
        else passes++;
        cyc(1);
        checks++;
        if (cnt_lo !== 3'd0 || cnt_hi !== 4'd1)
            $display("FAIL carry_wrap: lo=%0d hi=%0d want 0 1", cnt_lo, cnt_hi);
        else passes++;
    endtask

    task automatic test_pause();
        cyc(1);
        // Prescaler is two cycles into its period here.
        i_start = 1'b1;
        cyc(1);
        i_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            checks++;
            if (o_en_lo !== 1'b0 || o_en_hi !== 1'b0 || cnt_lo !== 3'd0 || cnt_hi !== 4'd1)
                $display("FAIL pause_frozen: cycle %0d en_lo=%b en_hi=%b lo=%0d hi=%0d",
                         i, o_en_lo, o_en_hi, cnt_lo, cnt_hi);
            else passes++;
        end
        checks++;
        if (o_running !== 1'b0)
            $display("FAIL pause_running: got %b want 0", o_running);
        else passes++;
        i_start = 1'b1;
        cyc(1);
        i_start = 1'b0;
        cyc(1);
        checks++;
        if (o_en_lo !== 1'b0 || o_running !== 1'b1)
            $display("FAIL resume_early: en_lo=%b running=%b want 0 1", o_en_lo, o_running);
        else passes++;
        cyc(1);
        checks++;
        if (o_en_lo !== 1'b1)
            $display("FAIL resume_tick: en_lo=%b want 1", o_en_lo);
        else passes++;
        cyc(1);
        checks++;
        if (cnt_lo !== 3'd1)
            $display("FAIL resume_count: cnt_lo=%0d want 1", cnt_lo);
        else passes++;
    endtask

    task automatic test_simultaneous();
        i_start = 1'b1;
        i_clr   = 1'b1;
        cyc(1);
        i_start = 1'b0;
        i_clr   = 1'b0;
        checks++;
        if (o_sclr_lo !== 1'b0 || o_en_lo !== 1'b0)
            $display("FAIL sim_clear_entry: sclr_lo=%b en_lo=%b want 0 0", o_sclr_lo, o_en_lo);
        else passes++;
        cyc(1);
        checks++;
        if (o_sclr_lo !== 1'b1 || o_sclr_hi !== 1'b1 || o_running !== 1'b0 || o_en_lo !== 1'b0)
            $display("FAIL sim_clear_pulse: sclr_lo=%b sclr_hi=%b running=%b en_lo=%b",
                     o_sclr_lo, o_sclr_hi, o_running, o_en_lo);
        else passes++;
        cyc(1);
        checks++;
        if (cnt_lo !== 3'd0 || cnt_hi !== 4'd0)
            $display("FAIL sim_counters: lo=%0d hi=%0d want 0 0", cnt_lo, cnt_hi);
        else passes++;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            checks++;
            if (o_en_lo !== 1'b0 || o_running !== 1'b0)
                $display("FAIL sim_idle: cycle %0d en_lo=%b running=%b", i, o_en_lo, o_running);
            else passes++;
        end
        i_start = 1'b1;
        cyc(1);
        i_start = 1'b0;
        cyc(1);
        checks++;
        if (o_running !== 1'b1)
            $display("FAIL sim_restart: running=%b want 1", o_running);
        else passes++;
        cyc(1);
        i_sclr = 1'b1;
        cyc(1);
        i_sclr = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            checks++;
            if (o_en_lo !== 1'b0 || o_en_hi !== 1'b0 || o_running !== 1'b0)
                $display("FAIL sclr_abort: cycle %0d en_lo=%b en_hi=%b running=%b",
                         i, o_en_lo, o_en_hi, o_running);
            else passes++;
        end
    endtask

`ifdef STOPWATCH_LAP_EN
    task automatic test_lap();
        i_lap = 1'b1;
        cyc(1);
        i_lap = 1'b0;
        checks++;
        if (o_lap_hold !== 1'b0)
            $display("FAIL lap_idle: got %b want 0", o_lap_hold);
        else passes++;
        i_start = 1'b1;
        cyc(1);
        i_start = 1'b0;
        i_lap = 1'b1;
        cyc(1);
        i_lap = 1'b0;
        checks++;
        if (o_lap_hold !== 1'b1)
            $display("FAIL lap_set: got %b want 1", o_lap_hold);
        else passes++;
        cyc(8);
        checks++;
        if (cnt_lo !== 3'd2)
            $display("FAIL lap_counting: cnt_lo=%0d want 2", cnt_lo);
        else passes++;
        i_lap = 1'b1;
        cyc(1);
        checks++;
        if (o_lap_hold !== 1'b0)
            $display("FAIL lap_toggle_off: got %b want 0", o_lap_hold);
        else passes++;
        cyc(1);
        i_lap = 1'b0;
        checks++;
        if (o_lap_hold !== 1'b1)
            $display("FAIL lap_toggle_on: got %b want 1", o_lap_hold);
        else passes++;
        i_clr = 1'b1;
        cyc(1);
        i_clr = 1'b0;
        cyc(1);
        checks++;
        if (o_lap_hold !== 1'b0)
            $display("FAIL lap_clear: got %b want 0", o_lap_hold);
        else passes++;
    endtask
`endif

    initial begin
        test_reset();
        test_count();
        test_carry();
        test_pause();
        test_simultaneous();
`ifdef STOPWATCH_LAP_EN
        test_lap();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
